// File: rtl/cpu_bus_master.sv
// cpu_bus_master: runs one request/response transaction at a time over the muxed C1/A1/D1 cache bus.
// Latency: 4 cycles handshake->RSP_VALID with an immediate RESPONSE (5 for READ32); RSP_VALID is a 1-cycle pulse.
// Backpressure: REQ_READY only in IDLE, one transaction outstanding. Macro CPU_BUS_TIMEOUT_EN adds a response watchdog.
module cpu_bus_master #(
    parameter int ADDR_W         = 19,
    parameter int OFFSET_W       = 4,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       REQ_VALID,
    output logic                       REQ_READY,
    input  logic [2:0]                 REQ_CMD,
    input  logic [ADDR_W-1:0]          REQ_ADDR,
    input  logic [2*DATA_W-1:0]        REQ_WDATA,
    output logic                       RSP_VALID,
    output logic [2*DATA_W-1:0]        RSP_RDATA,
    output logic                       RSP_ERR,
    output logic [2:0]                 C1_O,
    output logic                       C1_OE,
    input  logic [2:0]                 C1_I,
    output logic [ADDR_W-OFFSET_W-1:0] A1_O,
    output logic                       A1_OE,
    output logic [DATA_W-1:0]          D1_O,
    output logic                       D1_OE,
    input  logic [DATA_W-1:0]          D1_I
);
    localparam int A1_W  = ADDR_W - OFFSET_W;
    localparam int RSP_W = 2 * DATA_W;

    localparam logic [2:0] CMD_NOP      = 3'd0;
    localparam logic [2:0] CMD_READ8    = 3'd1;
    localparam logic [2:0] CMD_READ16   = 3'd2;
    localparam logic [2:0] CMD_READ32   = 3'd3;
    localparam logic [2:0] CMD_WRITE8   = 3'd5;
    localparam logic [2:0] CMD_WRITE16  = 3'd6;
    localparam logic [2:0] CMD_WRITE32  = 3'd7;
    localparam logic [2:0] CMD_RESPONSE = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_TURN,
        ST_WAIT_RSP,
        ST_RDATA_HI
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           cmd_q, cmd_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [RSP_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W-1:0]    lo_q, lo_d;
    logic                 rsp_vld_q, rsp_vld_d;
    logic [RSP_W-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic [2:0]           c1_o_q, c1_o_d;
    logic                 c1_oe_q, c1_oe_d;
    logic [A1_W-1:0]      a1_o_q, a1_o_d;
    logic                 a1_oe_q, a1_oe_d;
    logic [DATA_W-1:0]    d1_o_q, d1_o_d;
    logic                 d1_oe_q, d1_oe_d;
    logic [RSP_W-1:0]     beat_rdata;
    logic                 is_write_d;

`ifdef CPU_BUS_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
    logic                 rsp_err_q, rsp_err_d;
    assign RSP_ERR = rsp_err_q;
`else
    logic                 unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign RSP_ERR = 1'b0;
`endif

    // Single-beat read result; READ32 is assembled separately in RDATA_HI.
    always_comb begin
        beat_rdata = '0;
        case (cmd_q)
            CMD_READ8:  beat_rdata = RSP_W'(D1_I[7:0]);
            CMD_READ16: beat_rdata = RSP_W'(D1_I);
            default:    beat_rdata = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        lo_d        = lo_q;
        rsp_vld_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
`ifdef CPU_BUS_TIMEOUT_EN
        rsp_err_d   = rsp_err_q;
        to_cnt_d    = to_cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (REQ_VALID) begin
                    cmd_d   = REQ_CMD;
                    addr_d  = REQ_ADDR;
                    wdata_d = REQ_WDATA;
                    if (REQ_CMD != CMD_NOP) begin
                        state_d = ST_ADDR_HI;
                    end
                end
            end
            ST_ADDR_HI: state_d = ST_ADDR_LO;
            ST_ADDR_LO: state_d = ST_TURN;
            ST_TURN: begin
                state_d = ST_WAIT_RSP;
`ifdef CPU_BUS_TIMEOUT_EN
                to_cnt_d = '0;
`endif
            end
            ST_WAIT_RSP: begin
                // A RESPONSE in the watchdog's final cycle still completes normally.
                if (C1_I == CMD_RESPONSE) begin
                    if (cmd_q == CMD_READ32) begin
                        lo_d    = D1_I;
                        state_d = ST_RDATA_HI;
                    end else begin
                        state_d     = ST_IDLE;
                        rsp_vld_d   = 1'b1;
                        rsp_rdata_d = beat_rdata;
`ifdef CPU_BUS_TIMEOUT_EN
                        rsp_err_d   = 1'b0;
`endif
                    end
                end
`ifdef CPU_BUS_TIMEOUT_EN
                else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = ST_IDLE;
                    rsp_vld_d   = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
`endif
            end
            ST_RDATA_HI: begin
                state_d     = ST_IDLE;
                rsp_vld_d   = 1'b1;
                rsp_rdata_d = {D1_I, lo_q};
`ifdef CPU_BUS_TIMEOUT_EN
                rsp_err_d   = 1'b0;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus drives are registered and decoded from the next state, so they line up with the state they belong to.
    always_comb begin
        c1_oe_d    = 1'b0;
        a1_oe_d    = 1'b0;
        d1_oe_d    = 1'b0;
        c1_o_d     = '0;
        a1_o_d     = '0;
        d1_o_d     = '0;
        is_write_d = (cmd_d == CMD_WRITE8) || (cmd_d == CMD_WRITE16) || (cmd_d == CMD_WRITE32);
        case (state_d)
            ST_ADDR_HI: begin
                c1_oe_d = 1'b1;
                a1_oe_d = 1'b1;
                c1_o_d  = cmd_d;
                a1_o_d  = addr_d[ADDR_W-1:OFFSET_W];
                if (is_write_d) begin
                    d1_oe_d = 1'b1;
                    d1_o_d  = (cmd_d == CMD_WRITE8) ? DATA_W'(wdata_d[7:0]) : wdata_d[DATA_W-1:0];
                end
            end
            ST_ADDR_LO: begin
                c1_oe_d = 1'b1;
                a1_oe_d = 1'b1;
                c1_o_d  = cmd_d;
                a1_o_d  = A1_W'(addr_d[OFFSET_W-1:0]);
                if (cmd_d == CMD_WRITE32) begin
                    d1_oe_d = 1'b1;
                    d1_o_d  = wdata_d[RSP_W-1:DATA_W];
                end
            end
            default: begin
                c1_oe_d = 1'b0;
                a1_oe_d = 1'b0;
                d1_oe_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= ST_IDLE;
            cmd_q       <= CMD_NOP;
            addr_q      <= '0;
            wdata_q     <= '0;
            lo_q        <= '0;
            rsp_vld_q   <= 1'b0;
            rsp_rdata_q <= '0;
            c1_o_q      <= '0;
            c1_oe_q     <= 1'b0;
            a1_o_q      <= '0;
            a1_oe_q     <= 1'b0;
            d1_o_q      <= '0;
            d1_oe_q     <= 1'b0;
`ifdef CPU_BUS_TIMEOUT_EN
            to_cnt_q    <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            lo_q        <= lo_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_rdata_q <= rsp_rdata_d;
            c1_o_q      <= c1_o_d;
            c1_oe_q     <= c1_oe_d;
            a1_o_q      <= a1_o_d;
            a1_oe_q     <= a1_oe_d;
            d1_o_q      <= d1_o_d;
            d1_oe_q     <= d1_oe_d;
`ifdef CPU_BUS_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign REQ_READY = (state_q == ST_IDLE);
    assign RSP_VALID = rsp_vld_q;
    assign RSP_RDATA = rsp_rdata_q;
    assign C1_O      = c1_o_q;
    assign C1_OE     = c1_oe_q;
    assign A1_O      = a1_o_q;
    assign A1_OE     = a1_oe_q;
    assign D1_O      = d1_o_q;
    assign D1_OE     = d1_oe_q;

endmodule

// File: tb/tb_cpu_bus_master.sv
// Directed bench for cpu_bus_master: driver pushes expected responses, a negedge monitor pops and compares.
module tb_cpu_bus_master;
    localparam int ADDR_W = 19;
    localparam int A1_W   = 15;

    localparam logic [2:0] NOP = 3'd0, R8 = 3'd1, R16 = 3'd2, R32 = 3'd3;
    localparam logic [2:0] INV = 3'd4, W8 = 3'd5, W16 = 3'd6, W32 = 3'd7;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              REQ_VALID;
    logic              REQ_READY;
    logic [2:0]        REQ_CMD;
    logic [ADDR_W-1:0] REQ_ADDR;
    logic [31:0]       REQ_WDATA;
    logic              RSP_VALID;
    logic [31:0]       RSP_RDATA;
    logic              RSP_ERR;
    logic [2:0]        C1_O;
    logic              C1_OE;
    logic [2:0]        C1_I;
    logic [A1_W-1:0]   A1_O;
    logic              A1_OE;
    logic [15:0]       D1_O;
    logic              D1_OE;
    logic [15:0]       D1_I;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          hs_cyc;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    cpu_bus_master #(
        .ADDR_W(19), .OFFSET_W(4), .DATA_W(16), .TIMEOUT_CYCLES(8)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_CMD(REQ_CMD),
        .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
        .C1_O(C1_O), .C1_OE(C1_OE), .C1_I(C1_I),
        .A1_O(A1_O), .A1_OE(A1_OE),
        .D1_O(D1_O), .D1_OE(D1_OE), .D1_I(D1_I)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every RSP_VALID pulse must match the oldest expected response.
    always @(negedge CLK) begin
        if (RSP_VALID === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp actual=rdata %h err %b expected=no response (t=%0t)",
                         RSP_RDATA, RSP_ERR, $time);
            end else begin
                mon_e = sb_q.pop_front();
                check("rsp_rdata", 64'(RSP_RDATA), 64'(mon_e.rdata));
                check("rsp_err", 64'(RSP_ERR), 64'(mon_e.err));
                if (mon_e.lat >= 0) check("rsp_latency", 64'(cyc - mon_e.hs_cyc), 64'(mon_e.lat));
            end
        end
    end

    // Called right after a negedge; returns just after the handshake posedge.
    task automatic send(input logic [2:0] cmd, input logic [18:0] addr, input logic [31:0] wd,
                        input logic exp_rsp, input logic [31:0] exp_rd, input logic exp_err, input int lat);
        int n = 0;
        REQ_VALID = 1'b1;
        REQ_CMD   = cmd;
        REQ_ADDR  = addr;
        REQ_WDATA = wd;
        while (REQ_READY !== 1'b1 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (REQ_READY !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL req_ready_wait actual=%b expected=1 within 50 cycles", REQ_READY);
            REQ_VALID = 1'b0;
        end else begin
            if (exp_rsp) sb_q.push_back('{exp_rd, exp_err, cyc + 1, lat});
            @(posedge CLK);
        end
    endtask

    // Walks ADDR_HI/ADDR_LO/TURN checking drives, then answers after 'delay' WAIT_RSP cycles
    // (delay<0: never answer, return at TURN). Ends at the negedge of the RSP_VALID cycle.
    task automatic run_bus(input logic [2:0] cmd, input logic [18:0] addr, input logic [31:0] wd,
                           input int delay, input logic early, input logic [15:0] dlo, input logic [15:0] dhi,
                           input logic nv, input logic [2:0] ncmd, input logic [18:0] naddr,
                           input logic [31:0] nwd);
        logic        wr;
        logic [15:0] hi_d;
        wr   = (cmd == W8) || (cmd == W16) || (cmd == W32);
        hi_d = (cmd == W8) ? {8'h00, wd[7:0]} : wd[15:0];
        @(negedge CLK);
        REQ_VALID = nv;
        REQ_CMD   = ncmd;
        REQ_ADDR  = naddr;
        REQ_WDATA = nwd;
        if (early) C1_I = 3'd7;
        check("hi_c1a1_oe", 64'({C1_OE, A1_OE}), 64'(2'b11));
        check("hi_c1_o", 64'(C1_O), 64'(cmd));
        check("hi_a1_o", 64'(A1_O), 64'(addr[18:4]));
        check("hi_d1_oe", 64'(D1_OE), 64'(wr));
        if (wr) check("hi_d1_o", 64'(D1_O), 64'(hi_d));
        @(negedge CLK);
        check("lo_c1a1_oe", 64'({C1_OE, A1_OE}), 64'(2'b11));
        check("lo_c1_o", 64'(C1_O), 64'(cmd));
        check("lo_a1_o", 64'(A1_O), 64'(addr[3:0]));
        check("lo_d1_oe", 64'(D1_OE), 64'(cmd == W32));
        if (cmd == W32) check("lo_d1_o", 64'(D1_O), 64'(wd[31:16]));
        @(negedge CLK);
        C1_I = 3'd0;
        check("turn_oe", 64'({C1_OE, A1_OE, D1_OE}), 64'd0);
        check("turn_ready", 64'(REQ_READY), 64'd0);
        if (delay < 0) return;
        repeat (delay + 1) @(negedge CLK);
        check("wait_oe", 64'({C1_OE, A1_OE, D1_OE}), 64'd0);
        C1_I = 3'd7;
        D1_I = dlo;
        @(negedge CLK);
        C1_I = 3'd0;
        if (cmd == R32) begin
            D1_I = dhi;
            @(negedge CLK);
        end
        D1_I = 16'h0000;
    endtask

    // Called just after a negedge; asserts reset mid-cycle and releases on a later negedge.
    task automatic do_reset(input string tag);
        #2 RESET = 1'b0;
        #1;
        check({tag, "_oe"}, 64'({C1_OE, A1_OE, D1_OE}), 64'd0);
        check({tag, "_bus_o"}, 64'({C1_O, A1_O, D1_O}), 64'd0);
        check({tag, "_rsp_valid"}, 64'(RSP_VALID), 64'd0);
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        #1 check({tag, "_ready_rel"}, 64'(REQ_READY), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=still running expected=finished by 100000");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        RESET     = 1'b1;
        REQ_VALID = 1'b0;
        REQ_CMD   = 3'd0;
        REQ_ADDR  = '0;
        REQ_WDATA = '0;
        C1_I      = 3'd0;
        D1_I      = 16'h0000;
        #1 RESET  = 1'b0;
        #1;
        check("rst_ready", 64'(REQ_READY), 64'd1);
        check("rst_rsp", 64'({RSP_VALID, RSP_ERR, RSP_RDATA}), 64'd0);
        check("rst_oe", 64'({C1_OE, A1_OE, D1_OE}), 64'd0);
        check("rst_bus_o", 64'({C1_O, A1_O, D1_O}), 64'd0);
        repeat (3) @(negedge CLK);
        RESET = 1'b1;

        // READ32 on the first edge after release, response one cycle late
        send(R32, 19'h00023, 32'h0, 1'b1, 32'hABCD1234, 1'b0, 6);
        run_bus(R32, 19'h00023, 32'h0, 1, 1'b0, 16'h1234, 16'hABCD, 1'b0, 3'd0, 19'h0, 32'h0);

        // NOP: no bus activity, no response, previous read data held
        @(negedge CLK);
        send(NOP, 19'h7FFFF, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0, 0);
        @(negedge CLK);
        REQ_VALID = 1'b0;
        check("nop_ready", 64'(REQ_READY), 64'd1);
        check("nop_oe", 64'({C1_OE, A1_OE, D1_OE}), 64'd0);
        check("nop_rdata_held", 64'(RSP_RDATA), 64'h00000000ABCD1234);

        send(W32, 19'h12345, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0, 4);
        run_bus(W32, 19'h12345, 32'hDEADBEEF, 0, 1'b0, 16'h5555, 16'h0, 1'b0, 3'd0, 19'h0, 32'h0);

        send(R8, 19'h7FFFF, 32'hFFFFFFFF, 1'b1, 32'h0000005A, 1'b0, 4);
        run_bus(R8, 19'h7FFFF, 32'hFFFFFFFF, 0, 1'b0, 16'hFF5A, 16'h0, 1'b0, 3'd0, 19'h0, 32'h0);

        // RESPONSE driven during ADDR_HI/ADDR_LO must be ignored
        @(negedge CLK);
        send(R16, 19'h00100, 32'h0, 1'b1, 32'h00008001, 1'b0, 6);
        run_bus(R16, 19'h00100, 32'h0, 2, 1'b1, 16'h8001, 16'h0, 1'b0, 3'd0, 19'h0, 32'h0);

        send(W16, 19'h00ABC, 32'hCAFE1357, 1'b1, 32'h0, 1'b0, 4);
        run_bus(W16, 19'h00ABC, 32'hCAFE1357, 0, 1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 19'h0, 32'h0);

        // Back-to-back: WRITE8 held from ADDR_HI of READ16, accepted in the RSP_VALID cycle
        @(negedge CLK);
        send(R16, 19'h00040, 32'h0, 1'b1, 32'h0000BEEF, 1'b0, 4);
        run_bus(R16, 19'h00040, 32'h0, 0, 1'b0, 16'hBEEF, 16'h0, 1'b1, W8, 19'h00051, 32'hFFFFFF77);
        check("b2b_rsp_valid", 64'(RSP_VALID), 64'd1);
        check("b2b_ready", 64'(REQ_READY), 64'd1);
        send(W8, 19'h00051, 32'hFFFFFF77, 1'b1, 32'h0, 1'b0, 4);
        run_bus(W8, 19'h00051, 32'hFFFFFF77, 0, 1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 19'h0, 32'h0);

        // RESPONSE while idle
        @(negedge CLK);
        C1_I = 3'd7;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("idle_rsp_ready", 64'({REQ_READY, RSP_VALID}), 64'(2'b10));
        end
        C1_I = 3'd0;
        @(negedge CLK);

`ifdef CPU_BUS_TIMEOUT_EN
        send(R16, 19'h00200, 32'h0, 1'b1, 32'h0, 1'b1, 11);
        run_bus(R16, 19'h00200, 32'h0, -1, 1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 19'h0, 32'h0);
        repeat (10) @(negedge CLK);
        send(R16, 19'h00210, 32'h0, 1'b1, 32'h00004321, 1'b0, 11);
        run_bus(R16, 19'h00210, 32'h0, 7, 1'b0, 16'h4321, 16'h0, 1'b0, 3'd0, 19'h0, 32'h0);
        @(negedge CLK);
`else
        send(R16, 19'h00200, 32'h0, 1'b0, 32'h0, 1'b0, 0);
        run_bus(R16, 19'h00200, 32'h0, -1, 1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 19'h0, 32'h0);
        repeat (100) @(negedge CLK);
        check("no_timeout_ready", 64'({REQ_READY, RSP_ERR}), 64'd0);
        do_reset("stuck_rst");
`endif

        // Reset while driving the bus in ADDR_HI
        send(W32, 19'h00777, 32'h01234567, 1'b0, 32'h0, 1'b0, 0);
        @(negedge CLK);
        REQ_VALID = 1'b0;
        check("arst_pre_oe", 64'({C1_OE, A1_OE, D1_OE}), 64'(3'b111));
        do_reset("hi_rst");
        repeat (6) @(negedge CLK);

        // INVALIDATE abandoned by reset in WAIT_RSP, then an immediate READ8
        send(INV, 19'h00456, 32'h0, 1'b0, 32'h0, 1'b0, 0);
        run_bus(INV, 19'h00456, 32'h0, -1, 1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 19'h0, 32'h0);
        @(negedge CLK);
        check("inv_wait_ready", 64'(REQ_READY), 64'd0);
        do_reset("inv_rst");
        send(R8, 19'h00001, 32'h0, 1'b1, 32'h000000C3, 1'b0, 4);
        run_bus(R8, 19'h00001, 32'h0, 0, 1'b0, 16'h12C3, 16'h0, 1'b0, 3'd0, 19'h0, 32'h0);

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge CLK);
        check("sb_drain", 64'(sb_q.size()), 64'd0);
        repeat (2) @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
